// File: rtl/bfly_seq.sv
// bfly_seq: micro-sequencer running a batch of radix-2 real butterflies X=A+W*B, Y=A-W*B
// over a dual-read/dual-write 16-entry register file (W in signed Q1.FRAC).
// Latency: 3 cycles per butterfly plus 1 DONE cycle; count=0 completes in 1 cycle.
// Build option: define BFLY_SAT_EN to saturate X/Y to n bits; otherwise they wrap.
module bfly_seq #(
  parameter int n    = 8,
  parameter int FRAC = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   count,
  input  logic [3:0]   a_addr,
  input  logic [3:0]   b_addr,
  input  logic [3:0]   w_addr,
  input  logic [3:0]   x_addr,
  input  logic [3:0]   y_addr,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   R1addr1,
  output logic [3:0]   R1addr2,
  output logic [3:0]   R2addr1,
  output logic [3:0]   R2addr2,
  output logic [3:0]   R1addr3,
  output logic [3:0]   R2addr3,
  output logic         w1,
  output logic         w2,
  output logic [n-1:0] Wdata1,
  output logic [n-1:0] Wdata2,
  input  logic [n-1:0] R1data1,
  input  logic [n-1:0] R1data2,
  input  logic [n-1:0] R2data1,
  input  logic [n-1:0] R2data2
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MUL, S_WRITE, S_DONE} state_t;

  localparam logic signed [n+1:0] SAT_MAX = {3'b000, {(n-1){1'b1}}};
  localparam logic signed [n+1:0] SAT_MIN = {3'b111, {(n-1){1'b0}}};

  state_t              r_state;
  logic [3:0]          r_cnt, r_idx;
  logic [3:0]          r_a, r_b, r_w, r_x, r_y;
  logic signed [n-1:0] r_da, r_db, r_dw;
  logic                r_busy, r_done, r_err, r_wen;
  logic [3:0]          r_ra, r_rb, r_rw, r_wx, r_wy;
  logic [n-1:0]        r_wd1, r_wd2;

  logic [3:0]            w_ax, w_ay, w_idx_nxt;
  logic                  w_bad, w_last;
  logic signed [2*n-1:0] w_prod, w_shift;
  logic signed [n:0]     w_p;
  logic signed [n+1:0]   w_sum, w_dif;
  logic                  w_unused;

  // Destination addresses of the current butterfly wrap modulo 16.
  assign w_ax      = r_x + r_idx;
  assign w_ay      = r_y + r_idx;
  assign w_bad     = (w_ax < 4'd3) || (w_ay < 4'd3) || (w_ax == w_ay);
  assign w_last    = (r_idx == (r_cnt - 4'd1));
  assign w_idx_nxt = r_idx + 4'd1;

  // Full-width signed product, arithmetic shift floors toward -inf; keep n+1 bits.
  assign w_prod  = (2*n)'(r_db) * (2*n)'(r_dw);
  assign w_shift = w_prod >>> FRAC;
  assign w_p     = w_shift[n:0];

  // Butterfly sums carried at n+2 bits so neither can overflow before reduction.
  assign w_sum = {{2{r_da[n-1]}}, r_da} + {w_p[n], w_p};
  assign w_dif = {{2{r_da[n-1]}}, r_da} - {w_p[n], w_p};

  // Fourth read port and the discarded product bits are intentionally ignored.
  assign w_unused = ^{R2data2, w_shift[2*n-1:n+1]};

  function automatic logic [n-1:0] reduce(input logic signed [n+1:0] v);
`ifdef BFLY_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[n-1:0];
    if (v < SAT_MIN) return SAT_MIN[n-1:0];
`endif
    return v[n-1:0];
  endfunction

  // Sequencer FSM; every port is driven from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_w     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_da    <= '0;
      r_db    <= '0;
      r_dw    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wen   <= 1'b0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rw    <= '0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_wd1   <= '0;
      r_wd2   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= count;
            r_a    <= a_addr;
            r_b    <= b_addr;
            r_w    <= w_addr;
            r_x    <= x_addr;
            r_y    <= y_addr;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            if (count == 4'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ra    <= a_addr;
              r_rb    <= b_addr;
              r_rw    <= w_addr;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_da <= R1data1;
          r_db <= R1data2;
          r_dw <= R2data1;
          r_ra <= '0;
          r_rb <= '0;
          r_rw <= '0;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_wen   <= 1'b1;
          r_wx    <= w_ax;
          r_wy    <= w_ay;
          r_wd1   <= reduce(w_sum);
          r_wd2   <= reduce(w_dif);
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_wen <= 1'b0;
          r_wx  <= '0;
          r_wy  <= '0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= w_idx_nxt;
            r_ra    <= r_a + w_idx_nxt;
            r_rb    <= r_b + w_idx_nxt;
            r_rw    <= r_w;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign R1addr1 = r_ra;
  assign R1addr2 = r_rb;
  assign R2addr1 = r_rw;
  assign R2addr2 = 4'd0;
  assign R1addr3 = r_wx;
  assign R2addr3 = r_wy;
  assign w1      = r_wen;
  assign w2      = r_wen;
  assign Wdata1  = r_wd1;
  assign Wdata2  = r_wd2;

endmodule

// File: tb/tb_bfly_seq.sv
// Bench for bfly_seq: register-file model, reference butterfly model, scoreboard monitor.
module tb_bfly_seq;
  localparam int N    = 8;
  localparam int FRAC = 6;

  typedef struct {
    int         cyc;
    logic [3:0] ax;
    logic [7:0] xd;
    logic [3:0] ay;
    logic [7:0] yd;
  } wr_t;

  typedef struct {
    int   cyc;
    logic e;
  } dn_t;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         start   = 1'b0;
  logic [3:0]   count   = '0;
  logic [3:0]   a_addr  = '0;
  logic [3:0]   b_addr  = '0;
  logic [3:0]   w_addr  = '0;
  logic [3:0]   x_addr  = '0;
  logic [3:0]   y_addr  = '0;
  logic         busy, done, err, w1, w2;
  logic [3:0]   R1addr1, R1addr2, R2addr1, R2addr2, R1addr3, R2addr3;
  logic [N-1:0] Wdata1, Wdata2, R1data1, R1data2, R2data1, R2data2;

  logic [N-1:0] rf     [16];
  logic [N-1:0] ld_img [16];
  logic         ld_vld = 1'b0;
  logic [N-1:0] mm     [16];
  logic [8:0]   sw;

  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_pass = 0;
  wr_t wq[$];
  dn_t dq[$];

  bfly_seq #(.n(N), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .a_addr(a_addr), .b_addr(b_addr), .w_addr(w_addr), .x_addr(x_addr), .y_addr(y_addr),
    .busy(busy), .done(done), .err(err),
    .R1addr1(R1addr1), .R1addr2(R1addr2), .R2addr1(R2addr1), .R2addr2(R2addr2),
    .R1addr3(R1addr3), .R2addr3(R2addr3), .w1(w1), .w2(w2),
    .Wdata1(Wdata1), .Wdata2(Wdata2),
    .R1data1(R1data1), .R1data2(R1data2), .R2data1(R2data1), .R2data2(R2data2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: combinational reads, writes to 0..2 dropped, bulk preload port.
  always @(posedge clk) begin
    if (ld_vld) begin
      for (int i = 0; i < 16; i++) rf[i] <= ld_img[i];
    end else begin
      if (w1 && R1addr3 >= 4'd3) rf[R1addr3] <= Wdata1;
      if (w2 && R2addr3 >= 4'd3) rf[R2addr3] <= Wdata2;
    end
  end
  assign R1data1 = rf[R1addr1];
  assign R1data2 = rf[R1addr2];
  assign R2data1 = rf[R2addr1];
  assign R2data2 = rf[R2addr2];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int red(input int v);
`ifdef BFLY_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  // Reference: walk the batch butterfly by butterfly on the model file mm.
  task automatic model(input int s, input int cnt, input int a, input int b, input int w,
                       input int x, input int y, input int lim);
    int ax, ay, av, bv, wv, pv;
    logic signed [8:0] p9;
    wr_t e;
    dn_t d;
    for (int i = 0; i < cnt; i++) begin
      if (i >= lim) return;
      ax = (x + i) % 16;
      ay = (y + i) % 16;
      if (ax < 3 || ay < 3 || ax == ay) begin
        d.cyc = s + 3*i + 1;
        d.e   = 1'b1;
        dq.push_back(d);
        return;
      end
      av = int'($signed(mm[(a + i) % 16]));
      bv = int'($signed(mm[(b + i) % 16]));
      wv = int'($signed(mm[w]));
      pv = (bv * wv) >>> FRAC;
      p9 = 9'(pv);
      pv = int'(p9);
      e.cyc = s + 3*i + 2;
      e.ax  = 4'(ax);
      e.ay  = 4'(ay);
      e.xd  = 8'(red(av + pv));
      e.yd  = 8'(red(av - pv));
      wq.push_back(e);
      mm[ax] = e.xd;
      mm[ay] = e.yd;
    end
    d.cyc = (cnt == 0) ? s : s + 3*cnt;
    d.e   = 1'b0;
    dq.push_back(d);
  endtask

  // Monitor: compare every write and every done pulse against the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    dn_t d;
    if (!reset) begin
      if (w1 || w2) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got w1=%0b w2=%0b at %0d/%0d, expected no write",
                   w1, w2, R1addr3, R2addr3);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_strobes", int'({w1, w2}), 3);
          chk("wr_x_addr", int'(R1addr3), int'(e.ax));
          chk("wr_x_data", int'(Wdata1), int'(e.xd));
          chk("wr_y_addr", int'(R2addr3), int'(e.ay));
          chk("wr_y_data", int'(Wdata2), int'(e.yd));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err", int'(err), int'(d.e));
        end
      end
    end
  end

  task automatic push_img();
    @(negedge clk);
    for (int i = 0; i < 16; i++) ld_img[i] = mm[i];
    ld_vld = 1'b1;
    @(negedge clk);
    ld_vld = 1'b0;
  endtask

  task automatic rand_img();
    for (int i = 3; i < 16; i++) mm[i] = 8'($urandom);
  endtask

  // mode 0: plain batch; 1: extra start while busy; 2: reset during MUL of 2nd butterfly.
  task automatic issue(input int cnt, input int a, input int b, input int w,
                       input int x, input int y, input int mode);
    int s;
    @(negedge clk);
    start  = 1'b1;
    count  = 4'(cnt);
    a_addr = 4'(a);
    b_addr = 4'(b);
    w_addr = 4'(w);
    x_addr = 4'(x);
    y_addr = 4'(y);
    s = cyc + 1;
    model(s, cnt, a, b, w, x, y, (mode == 2) ? 1 : cnt);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("err_clear_on_start", int'(err), 0);
    if (mode == 1 && cnt > 0) begin
      start  = 1'b1;
      count  = 4'(cnt ^ 5);
      a_addr = 4'(a + 1);
      b_addr = 4'(b + 2);
      x_addr = 4'(x + 1);
      y_addr = 4'(y + 7);
      @(negedge clk);
      start = 1'b0;
    end
    if (mode == 2) begin
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_w1", int'(w1), 0);
      chk("rst_w2", int'(w2), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_raddr", int'(R1addr1), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_keep_x", int'(rf[4'(x)]), int'(mm[x]));
      chk("rst_keep_y", int'(rf[4'(y)]), int'(mm[y]));
    end else begin
      repeat (3*cnt + 3) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
    end
    chk("wr_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
  endtask

  initial begin
    int cnt, a, b, w, x, y, mode;
    sw = 9'($urandom);
    for (int i = 0; i < 16; i++) mm[i] = '0;
    mm[1] = {7'b0, sw[8]};
    mm[2] = sw[7:0];
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_w", int'({w1, w2}), 0);
    chk("reset_raddr", int'({R1addr1, R1addr2, R2addr1, R2addr2}), 0);
    chk("reset_waddr", int'({R1addr3, R2addr3}), 0);
    chk("reset_wdata", int'({Wdata1, Wdata2}), 0);
    reset = 1'b0;

    // Single in-place butterfly.
    rand_img();
    mm[3] = 8'd10; mm[4] = 8'd20; mm[5] = 8'd64;
    push_img();
    issue(1, 3, 4, 5, 3, 4, 0);
    chk("single_x", int'(rf[3]), 30);
    chk("single_y", int'(rf[4]), 246);

    // Overflow of X.
    mm[3] = 8'd100; mm[4] = 8'd100; mm[5] = 8'd64;
    push_img();
    issue(1, 3, 4, 5, 6, 7, 0);
`ifdef BFLY_SAT_EN
    chk("ovf_x", int'(rf[6]), 127);
`else
    chk("ovf_x", int'(rf[6]), 200);
`endif
    chk("ovf_y", int'(rf[7]), 0);

    // Batch of three with W=0.5.
    rand_img();
    mm[5] = 8'd32;
    push_img();
    issue(3, 3, 6, 5, 9, 12, 0);

    // Illegal destinations, then a clean batch clears err.
    issue(2, 3, 4, 5, 2, 8, 0);
    chk("err_sticky_low", int'(err), 1);
    issue(1, 3, 4, 5, 7, 7, 0);
    chk("err_sticky_eq", int'(err), 1);
    issue(1, 3, 4, 5, 8, 9, 0);
    chk("err_cleared", int'(err), 0);

    // Empty batch and destination wrap into the read-only range.
    issue(0, 3, 4, 5, 6, 7, 0);
    issue(4, 14, 3, 5, 14, 8, 0);

    // Reset in the middle of a batch, then start while busy.
    rand_img();
    push_img();
    issue(3, 3, 6, 5, 9, 12, 2);
    issue(3, 3, 6, 5, 9, 12, 1);

    // Randomized batches.
    for (int it = 0; it < 40; it++) begin
      if (it % 4 == 0) begin
        rand_img();
        push_img();
      end
      cnt  = int'($urandom_range(0, 5));
      a    = int'($urandom_range(0, 15));
      b    = int'($urandom_range(0, 15));
      w    = int'($urandom_range(0, 15));
      x    = int'($urandom_range(3, 15));
      y    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(3, 15));
      mode = (it % 5 == 2) ? 1 : 0;
      issue(cnt, a, b, w, x, y, mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bfly_seq.md
Name: bfly_seq

Overview:
- Micro-sequencer for the dual-read/dual-write 16-entry register file in the FFT butterfly datapath.
- Runs a batch of radix-2 real butterflies: X = A + W*B and Y = A - W*B, with W in signed Q1.FRAC.
- Drives the file's six address ports, both write strobes and both write-data buses, and consumes its four read-data buses.
- Register addresses 0..2 are read-only sources: zero, SW[8] and SW[7:0]. Writable addresses are 3..15.

Parameters:
- n, 8, data width, signed two's complement.
- FRAC, 6, fraction bits of W. 64 represents 1.0 when FRAC=6.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- count  in  4  number of butterflies in the batch; 0 means none
- a_addr, b_addr, w_addr, x_addr, y_addr  in  4 each  base addresses
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- err  out  1  sticky abort flag; cleared on the next accepted start
- R1addr1, R1addr2, R2addr1  out  4  read addresses for A, B, W
- R2addr2  out  4  tied to 0
- R1addr3, R2addr3  out  4  write addresses for X, Y
- w1, w2  out  1  write strobes
- Wdata1, Wdata2  out  n  X and Y results
- R1data1, R1data2, R2data1, R2data2  in  n  combinational read data from the register file; R2data2 is unused

Behaviour:
- Reset:
  - Asynchronous: state=IDLE.
  - busy, done, err, w1, w2 = 0.
  - All address outputs and Wdata = 0.
  - Internal index and operand registers = 0.
- FSM states: IDLE, READ, MUL, WRITE, DONE.
- IDLE:
  - On start, latch count and all five addresses, set idx=0 and clear err.
  - If count==0, go to DONE; otherwise go to READ.
- READ (1 cycle):
  - Drive R1addr1=a+idx, R1addr2=b+idx, R2addr1=w_addr.
  - Register the A, B and W read data at the clock edge.
  - Check ax=x+idx and ay=y+idx. If ax<3, ay<3, or ax==ay: set err and go to DONE with no write.
  - Otherwise go to MUL.
- MUL (1 cycle):
  - p = (signed B * signed W) >>> FRAC, computed as a 2n-bit product with an arithmetic shift (truncation toward -inf).
  - Register the low n+1 bits of p.
  - Go to WRITE.
- WRITE (1 cycle):
  - w1=w2=1, R1addr3=ax, R2addr3=ay.
  - Wdata1 = A+p and Wdata2 = A-p, computed at n+2 bits then reduced per SAT_EN.
  - Outputs are registered so strobe, address and data are stable for the whole cycle.
  - If idx==count-1, go to DONE; otherwise idx++ and go to READ.
- DONE (1 cycle): done=1, then go to IDLE.
- Outside WRITE: w1=w2=0 and all address outputs are 0.
- Latency:
  - 3 cycles per butterfly, plus 1 for DONE.
  - count=N gives done 3N+1 cycles after the start edge.
  - count=0 gives done 1 cycle after the start edge.
- Address arithmetic wraps modulo 16. A wrapped write address <3 triggers err at that butterfly; earlier butterflies remain written.
- In-place operation (x==a, y==b) is legal: the reads for each butterfly precede its write.
- start while busy is ignored; latched configuration cannot change mid-batch.
- Reset mid-batch: FSM returns to IDLE and w1/w2 deassert immediately. Partially completed writes stand.

Optional Feature:
- Macro: BFLY_SAT_EN.
- Defined: Wdata1/Wdata2 saturate to [-2^(n-1), 2^(n-1)-1].
- Undefined: the low n bits are taken (two's-complement wrap).
- The multiply truncation in MUL is the same in both builds.

Test Plan:
- Single butterfly, A=10, B=20, W=64, count=1, x=a=3, y=b=4, w=5:
  - writes X=30, Y=-10 (0xF6) in the WRITE cycle;
  - done on cycle 4 after start; err=0.
- Overflow, A=100, B=100, W=64:
  - with BFLY_SAT_EN: X=127, Y=0;
  - without: X=0xC8, Y=0.
- Batch, count=3, a=3, b=6, x=9, y=12, W=32 (0.5):
  - writes hit register pairs (9,12), (10,13), (11,14);
  - done exactly 10 cycles after start.
- Illegal destinations:
  - x_addr=2 gives err=1, done pulse, and no w1/w2 assertion ever.
  - x_addr==y_addr=7 gives the same response.
  - A following valid start clears err.
- Reset asserted during MUL of the 2nd of 3 butterflies:
  - same-cycle w1=w2=0, busy=0, FSM in IDLE;
  - the 1st result stays in the file.
- start pulsed while busy with different addresses: ignored, and the batch completes with its original addresses.
